// File: rtl/cpu_pkg.sv
// Shared CPU constants: register file geometry, NZCV bit positions,
// the sequencer FSM encoding and the latched request controls.
package cpu_pkg;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int REG_AW   = 4;
  localparam int SHNUM_W  = 8;
  localparam int SHOP_W   = 3;
  localparam int ALUOP_W  = 4;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  typedef struct packed {
    logic [REG_AW-1:0]  rd;
    logic [SHNUM_W-1:0] shift_num;
    logic [SHOP_W-1:0]  shift_op;
    logic [ALUOP_W-1:0] alu_op;
    logic               s;
    logic               wb;
  } ctrl_t;
endpackage

// File: rtl/reg_file16.sv
// 16x32 register file: two async operand reads, one async debug read,
// and two write ports where the writeback port overrides the external one.
module reg_file16
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ext_we,
  input  logic [REG_AW-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  assign ra_data  = regs[ra_addr];
  assign rb_data  = regs[rb_addr];
  assign dbg_data = regs[dbg_addr];

  // Writeback is issued last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      if (ext_we) regs[ext_addr] <= ext_wdata;
      if (wb_we)  regs[wb_addr]  <= wb_data;
    end
  end
endmodule

// File: rtl/alu_exec_seq.sv
// Three-state execute sequencer: latch operands, sample the external ALU,
// then write back result/flags and pulse done.
module alu_exec_seq
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [REG_AW-1:0]  req_rd,
  input  logic [REG_AW-1:0]  req_rn,
  input  logic [REG_AW-1:0]  req_rm,
  input  logic [SHNUM_W-1:0] req_shift_num,
  input  logic [SHOP_W-1:0]  req_shift_op,
  input  logic [ALUOP_W-1:0] req_alu_op,
  input  logic               req_s,
  input  logic               req_wb,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_shift_data,
  output logic [SHNUM_W-1:0] alu_shift_num,
  output logic [SHOP_W-1:0]  alu_shift_op,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_s,
  output logic               alu_cin,
  input  logic [DATA_W-1:0]  alu_f,
  input  logic [3:0]         alu_nzcv,
  input  logic               ext_we,
  input  logic [REG_AW-1:0]  ext_addr,
  input  logic [DATA_W-1:0]  ext_wdata,
  output logic [3:0]         nzcv,
  output logic               done,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_rdata
);
  state_e            state;
  ctrl_t             ctrl;
  logic [DATA_W-1:0] op_a, op_b, res_f;
  logic [3:0]        res_nzcv;
  logic [DATA_W-1:0] rn_data, rm_data;
  logic              wb_we;

  assign wb_we = (state == ST_WB) && ctrl.wb;

  reg_file16 u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_addr  (req_rn),
    .ra_data  (rn_data),
    .rb_addr  (req_rm),
    .rb_data  (rm_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_rdata),
    .wb_we    (wb_we),
    .wb_addr  (ctrl.rd),
    .wb_data  (res_f),
    .ext_we   (ext_we),
    .ext_addr (ext_addr),
    .ext_wdata(ext_wdata)
  );

  // Operands are sampled from the pre-edge register contents, so a same-edge
  // ext write to rn/rm is not seen, while a writeback from the previous
  // request (already committed) is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ctrl     <= '0;
      op_a     <= '0;
      op_b     <= '0;
      res_f    <= '0;
      res_nzcv <= '0;
      nzcv     <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_a           <= rn_data;
            op_b           <= rm_data;
            ctrl.rd        <= req_rd;
            ctrl.shift_num <= req_shift_num;
            ctrl.shift_op  <= req_shift_op;
            ctrl.alu_op    <= req_alu_op;
            ctrl.s         <= req_s;
            ctrl.wb        <= req_wb;
            state          <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_f    <= alu_f;
          res_nzcv <= alu_nzcv;
          state    <= ST_WB;
        end
        ST_WB: begin
          if (ctrl.s) nzcv <= res_nzcv;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready      = (state == ST_IDLE);
  assign alu_a          = op_a;
  assign alu_shift_data = op_b;
  assign alu_shift_num  = ctrl.shift_num;
  assign alu_shift_op   = ctrl.shift_op;
  assign alu_op         = ctrl.alu_op;
  assign alu_s          = ctrl.s;
  assign alu_cin        = nzcv[NZCV_C];
endmodule

// File: doc/alu_exec_seq.md
ALU_EXEC_SEQ -- requirements
Module: alu_exec_seq

Interface
REQ-001 SHALL have `clk` (input, 1): the single clock; all state updates on its rising edge.
REQ-002 SHALL have `rst_n` (input, 1): asynchronous, active-low reset.
REQ-003 SHALL have request handshake ports: `req_valid` in 1, `req_ready` out 1.
REQ-004 SHALL have request register selects `req_rd`, `req_rn`, `req_rm`: each in 4, destination / A-source / shift-source.
REQ-005 SHALL have request controls: `req_shift_num` in 8, `req_shift_op` in 3, `req_alu_op` in 4.
REQ-006 SHALL have request flags: `req_s` in 1 (update flags), `req_wb` in 1 (write rd).
REQ-007 SHALL have ALU-side outputs: `alu_a` out 32, `alu_shift_data` out 32, `alu_shift_num` out 8, `alu_shift_op` out 3, `alu_op` out 4, `alu_s` out 1, `alu_cin` out 1.
REQ-008 SHALL have ALU-side inputs: `alu_f` in 32 (ALU result), `alu_nzcv` in 4 (`{N,Z,C,V}`).
REQ-009 SHALL have register preload ports: `ext_we` in 1, `ext_addr` in 4, `ext_wdata` in 32.
REQ-010 SHALL have status outputs: `nzcv` out 4 (architectural flags), `done` out 1 (one-cycle completion pulse).
REQ-011 SHALL have debug read ports: `dbg_addr` in 4, `dbg_rdata` out 32 (combinational read of the register file).

Function
REQ-012 SHALL hold 16 x 32-bit registers R0..R15 and a 4-bit NZCV register.
REQ-013 SHALL implement an FSM with states IDLE, EXEC and WB, where IDLE→EXEC on `req_valid && req_ready`, EXEC→WB always, and WB→IDLE always.
REQ-014 SHALL drive `req_ready` = 1 only in IDLE.
REQ-015 SHALL, on the accepting edge, capture R[rn] into the A operand register and R[rm] into the shift-data operand register, and latch rd, shift_num, shift_op, alu_op, s and wb.
REQ-016 SHALL drive the ALU outputs from the operand/control registers in every state, holding their last values when not in EXEC.
REQ-017 SHALL drive `alu_cin` = `nzcv[1]` (current C flag).
REQ-018 SHALL, on the EXEC→WB edge, capture `alu_f` and `alu_nzcv` into result registers.
REQ-019 SHALL, on the WB→IDLE edge, write the result to R[rd] if wb=1 and load NZCV from the captured flags if s=1; otherwise it leaves both unchanged.
REQ-020 SHALL raise `done` for exactly the one cycle following the WB→IDLE edge, which is also the first cycle `req_ready` is 1 again.
REQ-021 SHALL complete an accepted request with `done` high in the cycle beginning 3 edges after acceptance, so throughput is 1 request per 3 cycles.
REQ-022 SHALL, if a new request is accepted in that `done` cycle, read the registers already updated by the previous writeback.
REQ-023 SHALL honour `ext_we` in any state, writing `ext_wdata` to R[ext_addr].
REQ-024 SHALL, when an `ext_we` write and a WB write target the same register on the same edge, keep the WB write.
REQ-025 SHALL, when an `ext_we` write targets rn or rm on the accepting edge, capture the pre-write value.
REQ-026 SHALL ignore `req_valid` while not in IDLE; the request is not consumed.
REQ-027 SHALL treat R15 as an ordinary register with no PC semantics.

Reset
REQ-028 SHALL, on `rst_n`=0, immediately force: state IDLE, all R = 0, NZCV = 0, operand/control/result registers = 0, and `done` = 0.
REQ-029 SHALL, as a consequence of REQ-028, drive `req_ready` = 1 during reset.
REQ-030 SHALL, on reset asserted mid-operation, abandon the in-flight request with no writeback and no `done`.

Structure
REQ-031 SHALL take the following from the shared `cpu_pkg` package: the FSM state encoding, NZCV bit-index constants (N=3, Z=2, C=1, V=0), and the register-count and data-width constants.
REQ-032 SHALL instantiate one sub-module, `reg_file16`, providing 16x32 storage with two async read ports, one debug read port, and two prioritised write ports (WB over ext).
REQ-033 SHALL connect to the ALU wrapper combinationally with no additional registering in between.

Verification
REQ-034 SHALL cover a basic add: preload R1=5, R2=7; request rn=1, rm=2, rd=3, shift_num=0, ADD, s=1, wb=1 → `done` 3 cycles after acceptance, R3=12, NZCV=0000.
REQ-035 SHALL cover overflow flags: R1=0x7FFFFFFF, R2=1, ADD with s=1 → R3=0x80000000, NZCV=1001.
REQ-036 SHALL cover s=0 and wb=0: after NZCV=1001, issue SUB with s=0 and wb=0 → `done` pulses, rd unchanged, NZCV stays 1001.
REQ-037 SHALL cover back-to-back dependency: request R4=R3+R3 accepted in the `done` cycle of the R3 write → R4=2×new R3.
REQ-038 SHALL cover a write collision: `ext_we` to rd=3 with 0xDEAD on the same edge as WB of R3 → R3 holds the WB result.
REQ-039 SHALL cover reset in EXEC: pulse `rst_n` low → `done` never asserts, all registers 0, `req_ready`=1 immediately.
